sync_fifo_ctrl: RTL and testbench

- Parametrised single-clock synchronous FIFO with its own internal storage array, read/write pointers and occupancy tracking.
- Generalises the team's fixed 8-bit x 16 dual-port RAM into a full FIFO: configurable width and depth, full/empty and programmable almost-full/almost-empty flags, occupancy count, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain.

---
 rtl/sync_fifo_ctrl_if.sv | 31 +++
 rtl/sync_fifo_ctrl.sv | 109 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sync_fifo_ctrl.
// The master modport is the user side; the slave modport is the FIFO side.
interface sync_fifo_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_enable, write_data, read_enable,
        input  read_data, read_valid, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  write_enable, write_data, read_enable,
        output read_data, read_valid, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with internal storage, registered status flags, occupancy count
// and sticky overflow/underflow indicators.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = 12,
    parameter int unsigned AE_LEVEL   = 4
) (
    input logic            clk,
    input logic            rst,
    sync_fifo_ctrl_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfLevel  = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AeLevel  = (ADDR_WIDTH + 1)'(AE_LEVEL);

    if (DEPTH < 4 || DEPTH != (32'd1 << ADDR_WIDTH)) begin : gen_bad_depth
        $error("DEPTH must be a power of 2, at least 4, and equal 2**ADDR_WIDTH");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH - 1) begin : gen_bad_levels
        $error("AF_LEVEL must be in 1..DEPTH and AE_LEVEL in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_valid_q;
    logic                  full_q, empty_q, almost_full_q, almost_empty_q;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Accepts use the registered flags, so a write while full is refused even
    // if a read frees a slot in the same cycle.
    always_comb begin
        wr_acc      = bus.write_enable && !full_q;
        rd_acc      = bus.read_enable && !empty_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (bus.write_enable & full_q);
        underflow_d = underflow_q | (bus.read_enable & empty_q);

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            read_data_q    <= '0;
            read_valid_q   <= 1'b0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            read_valid_q   <= rd_acc;
            full_q         <= (count_d == DepthCnt);
            empty_q        <= (count_d == '0);
            almost_full_q  <= (count_d >= AfLevel);
            almost_empty_q <= (count_d <= AeLevel);
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            if (rd_acc) begin
                read_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= bus.write_data;
        end
    end

    assign bus.read_data    = read_data_q;
    assign bus.read_valid   = read_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model checked every cycle,
// plus directed literal expectations along the stimulus sequence.
module tb_sync_fifo_ctrl;

    localparam int unsigned Depth = 16;

    logic clk;
    logic rst;

    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sync_fifo_ctrl #(
        .DATA_WIDTH(8),
        .DEPTH     (16),
        .ADDR_WIDTH(4),
        .AF_LEVEL  (12),
        .AE_LEVEL  (4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Reference model: queue contents plus the last popped word.
    logic [7:0] q [$];
    logic [7:0] m_rd;
    bit         m_rv, m_ovf, m_unf;
    bit         was_full, was_empty;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_rd  = 8'h00;
            m_rv  = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (q.size() == Depth);
            was_empty = (q.size() == 0);
            if (bus.write_enable && was_full) m_ovf = 1'b1;
            if (bus.read_enable && was_empty) m_unf = 1'b1;
            m_rv = bus.read_enable && !was_empty;
            if (m_rv) m_rd = q.pop_front();
            if (bus.write_enable && !was_full) q.push_back(bus.write_data);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_count",      32'(bus.count),        32'(q.size()));
            chk("m_full",       32'(bus.full),         32'(q.size() == Depth));
            chk("m_empty",      32'(bus.empty),        32'(q.size() == 0));
            chk("m_afull",      32'(bus.almost_full),  32'(q.size() >= 12));
            chk("m_aempty",     32'(bus.almost_empty), 32'(q.size() <= 4));
            chk("m_read_valid", 32'(bus.read_valid),   32'(m_rv));
            chk("m_read_data",  32'(bus.read_data),    32'(m_rd));
            chk("m_overflow",   32'(bus.overflow),     32'(m_ovf));
            chk("m_underflow",  32'(bus.underflow),    32'(m_unf));
        end
    end

    // Inputs change 2 time units after the rising edge, well away from both edges.
    task automatic cycle(input bit we, input logic [7:0] wd, input bit re);
        bus.write_enable = we;
        bus.write_data   = wd;
        bus.read_enable  = re;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst              = 1'b1;
        bus.write_enable = 1'b0;
        bus.write_data   = 8'h00;
        bus.read_enable  = 1'b0;
        @(posedge clk);
        #2;

        // Reset held two cycles with a write request present.
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b1, 8'h55, 1'b0);
        armed = 1'b1;
        chk("rst_count",        32'(bus.count),        32'd0);
        chk("rst_empty",        32'(bus.empty),        32'd1);
        chk("rst_aempty",       32'(bus.almost_empty), 32'd1);
        chk("rst_full",         32'(bus.full),         32'd0);
        chk("rst_read_valid",   32'(bus.read_valid),   32'd0);
        chk("rst_overflow",     32'(bus.overflow),     32'd0);
        chk("rst_underflow",    32'(bus.underflow),    32'd0);
        rst = 1'b0;

        // Fill 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            chk("fill_count", 32'(bus.count), 32'(i + 1));
            if (i == 10) chk("fill_afull_11", 32'(bus.almost_full), 32'd0);
            if (i == 11) chk("fill_afull_12", 32'(bus.almost_full), 32'd1);
            if (i == 14) chk("fill_full_15",  32'(bus.full),        32'd0);
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        cycle(1'b1, 8'hAA, 1'b0);
        chk("ovf_flag",  32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count),    32'd16);

        // Drain: each word appears the cycle after its request.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("drain_valid", 32'(bus.read_valid), 32'd1);
            chk("drain_data",  32'(bus.read_data),  32'(i));
            if (i == 10) chk("drain_aempty_5", 32'(bus.almost_empty), 32'd0);
            if (i == 11) chk("drain_aempty_4", 32'(bus.almost_empty), 32'd1);
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("unf_flag",  32'(bus.underflow),  32'd1);
        chk("unf_data",  32'(bus.read_data),  32'h0F);
        chk("unf_valid", 32'(bus.read_valid), 32'd0);
        chk("ovf_sticky", 32'(bus.overflow),  32'd1);

        // Simultaneous read/write at count 5.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'h30 + i), 1'b1);
            chk("simul_count", 32'(bus.count), 32'd5);
            chk("simul_data",  32'(bus.read_data), (i < 5) ? 32'(8'h20 + i) : 32'(8'h30 + i - 5));
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("simul_tail", 32'(bus.read_data), 32'(8'h35 + i));
        end

        // Wrap-around: 10 in/out then 12 in/out crosses the pointer wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("wrap1_data", 32'(bus.read_data), 32'(8'h40 + i));
        end
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        chk("wrap_afull", 32'(bus.almost_full), 32'd1);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("wrap2_data", 32'(bus.read_data), 32'(8'h60 + i));
        end
        cycle(1'b0, 8'h00, 1'b0);
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Reset mid-operation at count 7 with a read in flight.
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
        chk("mid_count7", 32'(bus.count), 32'd7);
        cycle(1'b0, 8'h00, 1'b1);
        chk("mid_valid_pre", 32'(bus.read_valid), 32'd1);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        chk("mid_valid",     32'(bus.read_valid), 32'd0);
        chk("mid_count",     32'(bus.count),      32'd0);
        chk("mid_empty",     32'(bus.empty),      32'd1);
        chk("mid_overflow",  32'(bus.overflow),   32'd0);
        chk("mid_underflow", 32'(bus.underflow),  32'd0);
        rst = 1'b0;

        // Post-reset sanity: one word through.
        cycle(1'b1, 8'hC3, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("post_data",  32'(bus.read_data),  32'hC3);
        chk("post_valid", 32'(bus.read_valid), 32'd1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
